// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises and glitch-filters the A/B channels of an
// encoder or jog switch, then turns each valid Gray-code transition into a one-cycle
// count-enable pulse (step) with a held direction bit (upp) for the mod-N counter.
// A post-reset settle phase lets the synchronisers and filters fill with the real
// input levels so that no spurious step is produced at start-up.

module quad_step_decoder #(
  parameter int unsigned SYNC_STAGES = 2,  // 2..4
  parameter int unsigned FILT_CYCLES = 4   // 1..15
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  input  logic err_clr,
  output logic step,
  output logic upp,
  output logic err,
  output logic busy
);

  // Settle length covers the synchroniser depth plus one full filter window.
  localparam logic [4:0] SettleMax = 5'(SYNC_STAGES + FILT_CYCLES);
  localparam logic [3:0] FiltLast  = 4'(FILT_CYCLES - 1);

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic                   filt_a_q;
  logic                   filt_b_q;
  logic [3:0]             cnt_a_q;
  logic [3:0]             cnt_b_q;
  logic [1:0]             prev_q;
  logic [4:0]             settle_q;
  logic                   step_q;
  logic                   upp_q;
  logic                   err_q;
  logic                   busy_q;

  logic                   a_s;
  logic                   b_s;
  logic                   filt_a_d;
  logic                   filt_b_d;
  logic [3:0]             cnt_a_d;
  logic [3:0]             cnt_b_d;
  logic [1:0]             curr;
  logic [1:0]             up_next;
  logic [1:0]             down_next;
  logic                   is_up;
  logic                   is_down;
  logic                   is_illegal;

  assign a_s = sync_a_q[SYNC_STAGES-1];
  assign b_s = sync_b_q[SYNC_STAGES-1];

  // Input synchronisers: plain shift chains, only the last stage is used.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], a_in};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], b_in};
    end
  end

  // Glitch filters: a new level must persist FILT_CYCLES cycles before it is accepted.
  always_comb begin
    filt_a_d = filt_a_q;
    cnt_a_d  = '0;
    if (a_s != filt_a_q) begin
      if (cnt_a_q == FiltLast) begin
        filt_a_d = a_s;
      end else begin
        cnt_a_d = cnt_a_q + 4'd1;
      end
    end

    filt_b_d = filt_b_q;
    cnt_b_d  = '0;
    if (b_s != filt_b_q) begin
      if (cnt_b_q == FiltLast) begin
        filt_b_d = b_s;
      end else begin
        cnt_b_d = cnt_b_q + 4'd1;
      end
    end
  end

  // Gray-code decode of {A,B}: up is 00->10->11->01->00, down is the reverse.
  always_comb begin
    curr      = {filt_a_q, filt_b_q};
    up_next   = 2'b00;
    down_next = 2'b00;
    unique case (prev_q)
      2'b00: begin
        up_next   = 2'b10;
        down_next = 2'b01;
      end
      2'b10: begin
        up_next   = 2'b11;
        down_next = 2'b00;
      end
      2'b11: begin
        up_next   = 2'b01;
        down_next = 2'b10;
      end
      default: begin
        up_next   = 2'b00;
        down_next = 2'b11;
      end
    endcase
    is_up      = (curr == up_next);
    is_down    = (curr == down_next);
    is_illegal = ((curr ^ prev_q) == 2'b11);
  end

  // Control FSM with registered outputs; RUN is left only through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StInit;
      filt_a_q <= 1'b0;
      filt_b_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      prev_q   <= 2'b00;
      settle_q <= '0;
      step_q   <= 1'b0;
      upp_q    <= 1'b1;
      err_q    <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StInit: begin
          // Track the synchronised levels directly so RUN starts with prev == curr.
          filt_a_q <= a_s;
          filt_b_q <= b_s;
          prev_q   <= {a_s, b_s};
          cnt_a_q  <= '0;
          cnt_b_q  <= '0;
          step_q   <= 1'b0;
          if (settle_q == SettleMax) begin
            state_q <= StRun;
            busy_q  <= 1'b0;
          end else begin
            settle_q <= settle_q + 5'd1;
          end
        end
        StRun: begin
          filt_a_q <= filt_a_d;
          filt_b_q <= filt_b_d;
          cnt_a_q  <= cnt_a_d;
          cnt_b_q  <= cnt_b_d;
          prev_q   <= curr;
          step_q   <= is_up | is_down;
          if (is_up) begin
            upp_q <= 1'b1;
          end else if (is_down) begin
            upp_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StInit;
        end
      endcase

      // Sticky error: a new illegal transition wins over a coincident clear.
      if ((state_q == StRun) && is_illegal) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign step = step_q;
  assign upp  = upp_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with default parameters (2 sync stages,
// 4-cycle filter). Each phase sets the expected step/upp/err/busy profile relative
// to the first clock edge that sees the new input levels, then checks every cycle.

module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic reset;
  logic a_in;
  logic b_in;
  logic err_clr;
  logic step;
  logic upp;
  logic err;
  logic busy;

  int checks = 0;
  int errors = 0;

  // Expected profile of the current phase; t counts edges since the phase began.
  int   t;
  int   s1;
  int   s2;
  int   e_at;
  int   busy_until;
  logic u0;
  logic u1;
  logic u2;
  logic e0;
  logic e1;

  quad_step_decoder #(
    .SYNC_STAGES(2),
    .FILT_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a_in   (a_in),
    .b_in   (b_in),
    .err_clr(err_clr),
    .step   (step),
    .upp    (upp),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, observed, expected);
    end
  endtask

  task automatic phase(input int ns1, input int ns2, input logic nu0, input logic nu1,
                       input logic nu2, input logic ne0, input logic ne1, input int ne_at,
                       input int nbusy);
    t          = 0;
    s1         = ns1;
    s2         = ns2;
    u0         = nu0;
    u1         = nu1;
    u2         = nu2;
    e0         = ne0;
    e1         = ne1;
    e_at       = ne_at;
    busy_until = nbusy;
  endtask

  task automatic tick();
    logic xs;
    logic xu;
    logic xe;
    logic xb;
    @(posedge clk);
    #1;
    t++;
    xs = (t == s1) || (t == s2);
    if (s2 > 0 && t >= s2)      xu = u2;
    else if (s1 > 0 && t >= s1) xu = u1;
    else                        xu = u0;
    xe = (e_at > 0 && t >= e_at) ? e1 : e0;
    xb = (t < busy_until);
    chk("step", step, xs);
    chk("upp", upp, xu);
    chk("err", err, xe);
    chk("busy", busy, xb);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset   = 1'b1;
    a_in    = 1'b1;
    b_in    = 1'b1;
    err_clr = 1'b0;

    // Reset with both inputs high: busy for 7 cycles, never a step.
    phase(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8);
    tick();
    reset = 1'b0;
    ticks(11);

    // Re-reset with inputs low to start decoding from 00.
    a_in  = 1'b0;
    b_in  = 1'b0;
    reset = 1'b1;
    phase(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8);
    tick();
    reset = 1'b0;
    ticks(9);

    // Up sequence 10, 11, 01, 00: step on the 7th edge after each change.
    a_in = 1'b1;
    phase(7, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    ticks(10);
    b_in = 1'b1;
    phase(7, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    ticks(10);
    a_in = 1'b0;
    phase(7, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    ticks(10);
    b_in = 1'b0;
    phase(7, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    ticks(10);

    // Down 00->01: upp falls with the step and then holds.
    b_in = 1'b1;
    phase(7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    ticks(10);

    // Back to 00 (an up transition).
    b_in = 1'b0;
    phase(7, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    ticks(10);

    // 3-cycle glitch on A is swallowed by the filter.
    a_in = 1'b1;
    phase(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    ticks(3);
    a_in = 1'b0;
    ticks(12);

    // 4-cycle pulse on A passes: up step, then down step four edges later.
    a_in = 1'b1;
    phase(7, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ticks(4);
    a_in = 1'b0;
    ticks(11);

    // Illegal 00->11: no step, err set on the 7th edge, upp held.
    a_in = 1'b1;
    b_in = 1'b1;
    phase(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 0);
    ticks(10);

    // err_clr for one cycle clears err at the next edge.
    err_clr = 1'b1;
    phase(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    tick();
    err_clr = 1'b0;
    ticks(3);

    // Illegal 11->00 with err_clr on the same edge: set wins.
    a_in = 1'b0;
    b_in = 1'b0;
    phase(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 0);
    ticks(6);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ticks(3);

    // Valid change, then reset two edges later: pending step dropped.
    a_in = 1'b1;
    phase(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    ticks(2);
    reset = 1'b1;
    phase(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8);
    tick();
    reset = 1'b0;
    ticks(13);

    // Decoding resumes from 10: 10->11 is up.
    b_in = 1'b1;
    phase(7, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    ticks(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
